// File: rtl/bp_common_cfg_link_pkg.sv
// rtl/bp_common_cfg_link_pkg.sv - shared types and address map for the config link
package bp_common_cfg_link_pkg;

    localparam int paddr_width_p    = 40;
    localparam int dword_width_p    = 64;
    localparam int vaddr_width_p    = 39;
    localparam int cce_id_width_p   = 7;
    localparam int cfg_dev_width_p  = 4;
    localparam int cfg_addr_width_p = 20;
    localparam int payload_width_p  = 16;
    localparam int nonlocal_width_p = paddr_width_p - cce_id_width_p - cfg_dev_width_p - cfg_addr_width_p;

    localparam logic [cfg_dev_width_p-1:0]  cfg_dev_gp = 4'd2;

    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_reset_gp           = 20'h00001;
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_freeze_gp          = 20'h00002;
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_icache_mode_gp     = 20'h00003;
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_dcache_mode_gp     = 20'h00004;
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_cce_mode_gp        = 20'h00005;
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_npc_gp             = 20'h00006;
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_mem_base_cce_ucode_gp  = 20'h08000;

    localparam logic [2:0] e_mem_size_8 = 3'd3;

    typedef enum logic [1:0] {
        e_lce_mode_uncached = 2'd0,
        e_lce_mode_normal   = 2'd1,
        e_lce_mode_nonspec  = 2'd2
    } bp_lce_mode_e;

    typedef enum logic {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_pre   = 4'd4
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [1:0] {
        e_ready    = 2'd0,
        e_ucode_rd = 2'd1,
        e_resp     = 2'd2
    } bp_cfg_state_e;

    typedef struct packed {
        bp_cce_mem_cmd_type_e           msg_type;
        logic [paddr_width_p-1:0]       addr;
        logic [payload_width_p-1:0]     payload;
        logic [2:0]                     size;
        logic [dword_width_p-1:0]       data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef struct packed {
        logic [nonlocal_width_p-1:0]    nonlocal;
        logic [cce_id_width_p-1:0]      cce;
        logic [cfg_dev_width_p-1:0]     dev;
        logic [cfg_addr_width_p-1:0]    addr;
    } bp_local_addr_s;

endpackage

// File: rtl/bp_cfg_mmio_responder_if.sv
// rtl/bp_cfg_mmio_responder_if.sv - command/response handshake bundle of the config link
interface bp_cfg_mmio_responder_if;
    import bp_common_cfg_link_pkg::*;

    bp_cce_mem_msg_s io_cmd;
    logic            io_cmd_v;
    logic            io_cmd_ready;
    bp_cce_mem_msg_s io_resp;
    logic            io_resp_v;
    logic            io_resp_yumi;

    modport master (
        output io_cmd, io_cmd_v, io_resp_yumi,
        input  io_cmd_ready, io_resp, io_resp_v
    );

    modport slave (
        input  io_cmd, io_cmd_v, io_resp_yumi,
        output io_cmd_ready, io_resp, io_resp_v
    );
endinterface

// File: rtl/bp_cfg_reg_file.sv
// rtl/bp_cfg_reg_file.sv - config register decode and storage
module bp_cfg_reg_file
    import bp_common_cfg_link_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         w_v,
    input  logic [cfg_addr_width_p-1:0]  addr,
    input  logic [dword_width_p-1:0]     wdata,
    output logic [dword_width_p-1:0]     rdata,
    output logic                         core_reset,
    output logic                         freeze,
    output bp_lce_mode_e                 icache_mode,
    output bp_lce_mode_e                 dcache_mode,
    output bp_cce_mode_e                 cce_mode,
    output logic [vaddr_width_p-1:0]     npc,
    output logic                         npc_w_v
);

    wire unused_wdata = ^wdata[dword_width_p-1:vaddr_width_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            core_reset  <= 1'b1;
            freeze      <= 1'b1;
            icache_mode <= e_lce_mode_uncached;
            dcache_mode <= e_lce_mode_uncached;
            cce_mode    <= e_cce_mode_uncached;
            npc         <= '0;
            npc_w_v     <= 1'b0;
        end else begin
            npc_w_v <= 1'b0;
            if (w_v) begin
                case (addr)
                    bp_cfg_reg_reset_gp:       core_reset  <= wdata[0];
                    bp_cfg_reg_freeze_gp:      freeze      <= wdata[0];
                    bp_cfg_reg_icache_mode_gp: icache_mode <= bp_lce_mode_e'(wdata[1:0]);
                    bp_cfg_reg_dcache_mode_gp: dcache_mode <= bp_lce_mode_e'(wdata[1:0]);
                    bp_cfg_reg_cce_mode_gp:    cce_mode    <= bp_cce_mode_e'(wdata[0]);
                    bp_cfg_reg_npc_gp: begin
                        npc     <= wdata[vaddr_width_p-1:0];
                        npc_w_v <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        case (addr)
            bp_cfg_reg_reset_gp:       rdata[0]                 = core_reset;
            bp_cfg_reg_freeze_gp:      rdata[0]                 = freeze;
            bp_cfg_reg_icache_mode_gp: rdata[1:0]               = icache_mode;
            bp_cfg_reg_dcache_mode_gp: rdata[1:0]               = dcache_mode;
            bp_cfg_reg_cce_mode_gp:    rdata[0]                 = cce_mode;
            bp_cfg_reg_npc_gp:         rdata[vaddr_width_p-1:0] = npc;
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_cfg_mmio_responder.sv
// rtl/bp_cfg_mmio_responder.sv - config link target: register file and microcode RAM access
module bp_cfg_mmio_responder
    import bp_common_cfg_link_pkg::*;
#(
    parameter int inst_width_p          = 32,
    parameter int inst_ram_addr_width_p = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [cce_id_width_p-1:0]        cce_id_i,
    bp_cfg_mmio_responder_if.slave           io,
    output logic                             reset_o,
    output logic                             freeze_o,
    output bp_lce_mode_e                     icache_mode_o,
    output bp_lce_mode_e                     dcache_mode_o,
    output bp_cce_mode_e                     cce_mode_o,
    output logic [vaddr_width_p-1:0]         npc_o,
    output logic                             npc_w_v_o,
    output logic                             ucode_v_o,
    output logic                             ucode_w_o,
    output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
    output logic [inst_width_p-1:0]          ucode_data_o,
    input  logic [inst_width_p-1:0]          ucode_data_i
);

    bp_cfg_state_e   state_r;
    bp_cce_mem_msg_s resp_r;
    bp_local_addr_s  cmd_addr;
    logic            hit, is_ucode, is_rd, is_wr, accept, reg_w_v;
    logic [cfg_addr_width_p-1:0] ucode_off;
    logic [dword_width_p-1:0]    reg_rdata;

    assign cmd_addr  = io.io_cmd.addr;
    assign hit       = (cmd_addr.dev == cfg_dev_gp) && (cmd_addr.cce == cce_id_i);
    assign is_ucode  = (cmd_addr.addr >= bp_cfg_mem_base_cce_ucode_gp);
    assign is_rd     = (io.io_cmd.msg_type == e_cce_mem_uc_rd);
    assign is_wr     = (io.io_cmd.msg_type == e_cce_mem_uc_wr);
    assign accept    = io.io_cmd_v && (state_r == e_ready);
    assign ucode_off = cmd_addr.addr - bp_cfg_mem_base_cce_ucode_gp;

    wire unused_addr = ^{ucode_off[cfg_addr_width_p-1:inst_ram_addr_width_p], cmd_addr.nonlocal};

    assign reg_w_v      = accept && hit && !is_ucode && is_wr;
    assign ucode_v_o    = accept && hit && is_ucode && (is_rd || is_wr);
    assign ucode_w_o    = ucode_v_o && is_wr;
    assign ucode_addr_o = ucode_off[inst_ram_addr_width_p-1:0];
    assign ucode_data_o = io.io_cmd.data[inst_width_p-1:0];

    bp_cfg_reg_file u_reg_file (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .w_v         (reg_w_v),
        .addr        (cmd_addr.addr),
        .wdata       (io.io_cmd.data),
        .rdata       (reg_rdata),
        .core_reset  (reset_o),
        .freeze      (freeze_o),
        .icache_mode (icache_mode_o),
        .dcache_mode (dcache_mode_o),
        .cce_mode    (cce_mode_o),
        .npc         (npc_o),
        .npc_w_v     (npc_w_v_o)
    );

    // Header is captured at accept; data is either the register value now or RAM data next cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
            resp_r  <= '0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (accept) begin
                        resp_r      <= io.io_cmd;
                        resp_r.data <= (hit && !is_ucode && is_rd) ? reg_rdata : '0;
                        state_r     <= (hit && is_ucode && is_rd) ? e_ucode_rd : e_resp;
                    end
                end
                e_ucode_rd: begin
                    resp_r.data <= dword_width_p'(ucode_data_i);
                    state_r     <= e_resp;
                end
                e_resp: begin
                    if (io.io_resp_yumi) state_r <= e_ready;
                end
                default: state_r <= e_ready;
            endcase
        end
    end

    assign io.io_cmd_ready = (state_r == e_ready);
    assign io.io_resp_v    = (state_r == e_resp);
    assign io.io_resp      = resp_r;

endmodule
